uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Oversampling UART receiver; serial-to-parallel front end of the system link.
- Converts the RX line into bytes for the system controller, which then issues RegFile writes and ALU commands.
- Counterpart of the UART_TX stage; shares its parity conventions (PAR_EN, PAR_TYP: 0 = even, 1 = odd).
- Runs on the reference clock with an internal oversampling counter; no divided clock is needed.

Parameters:
DATA_WD, 8, payload bits per frame (LSB first)
PRESCALE_WD, 6, width of the PRESCALE input

Ports:
CLK        input   1              system clock; all state on rising edge
RST        input   1              asynchronous, active-high reset
RX_IN      input   1              serial line, idle high, asynchronous to CLK
PRESCALE   input   PRESCALE_WD    oversampling ratio; legal values 8, 16, 32
PAR_EN     input   1              1 = frame carries a parity bit
PAR_TYP    input   1              0 = even parity, 1 = odd parity
P_DATA     output  DATA_WD        last good byte received
DATA_VLD   output  1              one-cycle pulse when P_DATA is updated
PAR_ERR    output  1              one-cycle pulse when a frame fails the parity check
STP_ERR    output  1              one-cycle pulse when the stop bit samples low

Interface: one clock (CLK); reset (RST) is asynchronous and active-high.

Behaviour:
- Reset: P_DATA=0, DATA_VLD=0, PAR_ERR=0, STP_ERR=0, FSM=IDLE, counters=0, synchronizer flops=1.
- RX_IN passes through a 2-flop synchronizer, giving rx_s; all timing below refers to rx_s.
- PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE->START transition. Changes mid-frame are ignored until the next frame.
- edge_cnt counts 0..P-1 within each bit (P = latched prescale); bit_cnt counts data bits 0..DATA_WD-1.
- Bit value is the majority of rx_s sampled at edge_cnt = P/2-1, P/2 and P/2+1. The decision is registered at P/2+1.
- FSM states and transitions:
  - IDLE: wait for rx_s==0. The cycle it is seen counts as edge_cnt 0 of START.
  - START: if the sampled start bit is 1 (glitch), return to IDLE at edge_cnt P-1 with no outputs. Otherwise go to DATA at edge_cnt P-1.
  - DATA: shift the sampled bit into shift_reg LSB first. After bit DATA_WD-1 at edge_cnt P-1, go to PARITY if PAR_EN, else to STOP.
  - PARITY: compare the sampled bit against (^shift_reg) XOR PAR_TYP. Record a mismatch in par_bad, then go to STOP.
  - STOP: at edge_cnt P-1, evaluate the frame and return to IDLE.
- Frame evaluation, in the cycle after STOP edge_cnt P-1:
  - Stop bit sampled 0: STP_ERR=1.
  - par_bad set: PAR_ERR=1.
  - Both errors may pulse together.
  - No error: DATA_VLD=1 and P_DATA<=shift_reg.
  - On any error P_DATA holds its previous value and DATA_VLD stays 0.
- Latency: DATA_VLD fires (2+DATA_WD+PAR_EN)*P cycles after the cycle rx_s is first seen low, plus 2 synchronizer cycles from RX_IN.
- Back-to-back frames: a start edge arriving on the same cycle as the evaluation pulse must be accepted. IDLE is checked that cycle, so no frame is lost.
- Reset mid-frame clears everything immediately. The next frame starts on the first low rx_s after RST deasserts.
- Line held low (break): produces STP_ERR for that frame, then restarts as a new frame while rx_s stays low. No lockup.
- An illegal PRESCALE value is a system error; behaviour is undefined but the FSM must still return to IDLE.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum {IDLE, START, DATA, PARITY, STOP};
  - constants for the legal prescale values (8/16/32);
  - the parity-type encoding (EVEN=0, ODD=1), shared with UART_TX.
- Sub-module uart_rx_sampler owns edge_cnt, the 3-point majority vote and the sample_done strobe. The FSM, shifter and checks stay in uart_rx.

Test Plan:
1. PRESCALE=8, PAR_EN=0, send 0xA5 -> DATA_VLD pulses once, exactly 80 cycles after rx_s falls; P_DATA=0xA5; no error pulses.
2. PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> P_DATA=0x3C, DATA_VLD pulses at cycle 176; then repeat with PAR_TYP=1 and parity bit 1 -> P_DATA=0x3C again.
3. PRESCALE=8, PAR_EN=1, PAR_TYP=0, send 0x01 with parity bit 0 -> PAR_ERR pulses once; DATA_VLD=0; P_DATA keeps its previous value.
4. PRESCALE=32, send 0x55 with stop bit 0, then a valid 0x0F with no idle gap -> STP_ERR on the first frame, then DATA_VLD with P_DATA=0x0F.
5. 3-cycle low glitch on RX_IN at PRESCALE=16, followed later by a valid 0x81 -> no output pulses for the glitch; 0x81 received correctly. Also a single-cycle corrupt sample inside a data bit -> still correct by majority vote.
6. Assert RST during DATA bit 4 of a frame -> all outputs 0 within the same cycle; a subsequent 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, legal oversampling
// ratios, the parity-type encoding used by both UART_TX and UART_RX, and the
// 3-point majority vote helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Legal oversampling ratios; anything else is a system error.
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Parity type encoding shared with UART_TX.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Majority of three samples; a single corrupted sample cannot flip a bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the UART receiver: counts oversampling edges within a
// bit, takes three samples around the bit centre and registers their majority.
// bit_val is valid from the cycle sample_done is high until the next vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WD = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_s,
  input  logic                   start,
  input  logic                   active,
  input  logic [PRESCALE_WD-1:0] prescale,
  output logic                   edge_last,
  output logic                   bit_val,
  output logic                   sample_done
);

  localparam logic [PRESCALE_WD-1:0] ONE = PRESCALE_WD'(1);

  logic [PRESCALE_WD-1:0] edge_cnt;
  logic [PRESCALE_WD-1:0] half;
  logic [PRESCALE_WD-1:0] half_m1;
  logic [PRESCALE_WD-1:0] half_p1;
  logic [PRESCALE_WD-1:0] last_edge;
  logic                   s_early;
  logic                   s_mid;

  assign half      = prescale >> 1;
  assign half_m1   = half - ONE;
  assign half_p1   = half + ONE;
  assign last_edge = prescale - ONE;
  assign edge_last = active && (edge_cnt == last_edge);

  // Edge counter: the start-detect cycle is edge 0, so the first counted
  // cycle inside START is edge 1; wraps to 0 at the end of every bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (start) begin
      edge_cnt <= ONE;
    end else if (!active || edge_last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + ONE;
    end
  end

  // Three samples around the bit centre; the vote is registered on the third.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_early     <= 1'b1;
      s_mid       <= 1'b1;
      bit_val     <= 1'b1;
      sample_done <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      if (active) begin
        if (edge_cnt == half_m1) s_early <= rx_s;
        if (edge_cnt == half)    s_mid   <= rx_s;
        if (edge_cnt == half_p1) begin
          bit_val     <= majority3(s_early, s_mid, rx_s);
          sample_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver. Synchronizes RX_IN, walks a start/data/parity/
// stop FSM on the reference clock and reports each frame with one-cycle
// pulses.
//
// Output handshake: DATA_VLD is a one-cycle valid with no ready; the consumer
// must take P_DATA in the cycle DATA_VLD is high. P_DATA then holds until the
// next good frame. PAR_ERR/STP_ERR pulse in the same evaluation cycle and
// never coincide with DATA_VLD.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WD     = 8,
  parameter int PRESCALE_WD = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESCALE_WD-1:0] PRESCALE,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic [DATA_WD-1:0]     P_DATA,
  output logic                   DATA_VLD,
  output logic                   PAR_ERR,
  output logic                   STP_ERR
);

  localparam int BIT_CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
  localparam logic [BIT_CNT_WD-1:0] LAST_BIT = BIT_CNT_WD'(DATA_WD - 1);
  localparam logic [BIT_CNT_WD-1:0] BIT_ONE  = BIT_CNT_WD'(1);

  rx_state_t              state;
  rx_state_t              next_state;

  logic                   sync_q;
  logic                   rx_s;
  logic [PRESCALE_WD-1:0] p_lat;
  logic                   par_en_lat;
  logic                   par_typ_lat;
  logic [BIT_CNT_WD-1:0]  bit_cnt;
  logic [DATA_WD-1:0]     shift_reg;
  logic                   par_bad;
  logic                   exp_par;

  logic                   start_det;
  logic                   active;
  logic                   edge_last;
  logic                   bit_val;
  logic                   sample_done;
  logic                   frame_done;
  logic                   shift_en;
  logic                   bit_adv;
  logic                   par_chk;

  assign start_det = (state == IDLE) && !rx_s;
  assign active    = (state != IDLE);
  assign exp_par   = (^shift_reg) ^ (par_typ_lat == PAR_ODD);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= RX_IN;
      rx_s   <= sync_q;
    end
  end

  uart_rx_sampler #(
    .PRESCALE_WD (PRESCALE_WD)
  ) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .rx_s        (rx_s),
    .start       (start_det),
    .active      (active),
    .prescale    (p_lat),
    .edge_last   (edge_last),
    .bit_val     (bit_val),
    .sample_done (sample_done)
  );

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    next_state = state;
    frame_done = 1'b0;
    shift_en   = 1'b0;
    bit_adv    = 1'b0;
    par_chk    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) next_state = START;
      end
      START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (edge_last) next_state = bit_val ? IDLE : DATA;
      end
      DATA: begin
        shift_en = sample_done;
        bit_adv  = edge_last;
        if (edge_last && (bit_cnt == LAST_BIT)) begin
          next_state = par_en_lat ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_chk = sample_done;
        if (edge_last) next_state = STOP;
      end
      STOP: begin
        frame_done = edge_last;
        if (edge_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame configuration capture, bit counting, shifting and parity check.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_lat       <= PRESCALE_WD'(PRESCALE_8);
      par_en_lat  <= 1'b0;
      par_typ_lat <= PAR_EVEN;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_bad     <= 1'b0;
    end else begin
      if (start_det) begin
        p_lat       <= PRESCALE;
        par_en_lat  <= PAR_EN;
        par_typ_lat <= PAR_TYP;
        bit_cnt     <= '0;
        par_bad     <= 1'b0;
      end
      if (shift_en) shift_reg <= {bit_val, shift_reg[DATA_WD-1:1]};
      if (bit_adv)  bit_cnt   <= bit_cnt + BIT_ONE;
      if (par_chk)  par_bad   <= (bit_val != exp_par);
    end
  end

  // Frame evaluation: pulses appear the cycle after the last stop-bit edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P_DATA   <= '0;
      DATA_VLD <= 1'b0;
      PAR_ERR  <= 1'b0;
      STP_ERR  <= 1'b0;
    end else begin
      DATA_VLD <= 1'b0;
      PAR_ERR  <= 1'b0;
      STP_ERR  <= 1'b0;
      if (frame_done) begin
        STP_ERR <= !bit_val;
        PAR_ERR <= par_bad;
        if (bit_val && !par_bad) begin
          DATA_VLD <= 1'b1;
          P_DATA   <= shift_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on RX_IN, a
// negedge monitor records output pulses, and each scenario task compares the
// recorded activity against hand-computed expectations.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int DATA_WD     = 8;
  localparam int PRESCALE_WD = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   rx_in = 1'b1;
  logic [PRESCALE_WD-1:0] prescale = 6'd8;
  logic                   par_en = 1'b0;
  logic                   par_typ = 1'b0;
  logic [DATA_WD-1:0]     p_data;
  logic                   data_vld;
  logic                   par_err;
  logic                   stp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int par_cnt  = 0;
  int stp_cnt  = 0;
  int vld_cyc  = 0;
  int fall_cyc = 0;
  logic [DATA_WD-1:0] got_q[$];
  logic [DATA_WD-1:0] exp_q[$];

  uart_rx #(
    .DATA_WD     (DATA_WD),
    .PRESCALE_WD (PRESCALE_WD)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX_IN    (rx_in),
    .PRESCALE (prescale),
    .PAR_EN   (par_en),
    .PAR_TYP  (par_typ),
    .P_DATA   (p_data),
    .DATA_VLD (data_vld),
    .PAR_ERR  (par_err),
    .STP_ERR  (stp_err)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_vld) begin
        got_q.push_back(p_data);
        vld_cnt = vld_cnt + 1;
        vld_cyc = cyc;
      end
      if (par_err) par_cnt = par_cnt + 1;
      if (stp_err) stp_cnt = stp_cnt + 1;
    end
  end

  // Watchdog: the directed sequence is fixed-length.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mon();
    vld_cnt = 0;
    par_cnt = 0;
    stp_cnt = 0;
    vld_cyc = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int p);
    rx_in = b;
    repeat (p) @(negedge clk);
  endtask

  // One data bit with a single-cycle inversion landing on the centre sample.
  task automatic drive_bit_corrupt(input logic b, input int p);
    rx_in = b;
    repeat (p / 2) @(negedge clk);
    rx_in = ~b;
    @(negedge clk);
    rx_in = b;
    repeat (p - p / 2 - 1) @(negedge clk);
  endtask

  // Full frame, LSB first; corrupt_bit selects a data bit to disturb (-1 none).
  task automatic send_frame(input logic [7:0] d, input int p, input logic with_par,
                            input logic par_bit, input logic stop_bit, input int corrupt_bit);
    fall_cyc = cyc;
    drive_bit(1'b0, p);
    for (int i = 0; i < DATA_WD; i++) begin
      if (i == corrupt_bit) drive_bit_corrupt(d[i], p);
      else                  drive_bit(d[i], p);
    end
    if (with_par) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
    rx_in = 1'b1;
  endtask

  task automatic check_byte(input string name);
    logic [DATA_WD-1:0] exp_b;
    logic [DATA_WD-1:0] got_b;
    checks++;
    if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: received %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      exp_b = exp_q.pop_front();
      got_b = got_q.pop_front();
      if (got_b !== exp_b) begin
        failures++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", name, got_b, exp_b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (p_data !== 8'h00) begin failures++; $display("FAIL reset_p_data: got 0x%02h expected 0x00", p_data); end
    checks++;
    if ({data_vld, par_err, stp_err} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses: got %b expected 000", {data_vld, par_err, stp_err});
    end
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
    checks++;
    if (dut.rx_s !== 1'b1) begin failures++; $display("FAIL reset_sync: got %b expected 1", dut.rx_s); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_p8_no_parity();
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    clear_mon();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(8);
    checks++;
    if (vld_cnt !== 1) begin failures++; $display("FAIL p8_vld_count: got %0d expected 1", vld_cnt); end
    checks++;
    if (vld_cyc - fall_cyc !== 82) begin failures++; $display("FAIL p8_latency: got %0d expected 82", vld_cyc - fall_cyc); end
    check_byte("p8_data");
    checks++;
    if (par_cnt + stp_cnt !== 0) begin failures++; $display("FAIL p8_errors: got %0d expected 0", par_cnt + stp_cnt); end
  endtask

  task automatic test_parity_ok();
    prescale = 6'd16; par_en = 1'b1; par_typ = PAR_EVEN;
    clear_mon();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
    idle(8);
    checks++;
    if (vld_cyc - fall_cyc !== 178) begin failures++; $display("FAIL even_latency: got %0d expected 178", vld_cyc - fall_cyc); end
    check_byte("even_data");
    checks++;
    if (par_cnt !== 0) begin failures++; $display("FAIL even_par_err: got %0d expected 0", par_cnt); end
    par_typ = PAR_ODD;
    clear_mon();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
    idle(8);
    checks++;
    if (vld_cnt !== 1 || par_cnt !== 0) begin
      failures++; $display("FAIL odd_pulses: vld %0d par %0d expected 1 0", vld_cnt, par_cnt);
    end
    check_byte("odd_data");
  endtask

  task automatic test_parity_error();
    prescale = 6'd8; par_en = 1'b1; par_typ = PAR_EVEN;
    clear_mon();
    send_frame(8'h01, 8, 1'b1, 1'b0, 1'b1, -1);
    idle(8);
    checks++;
    if (par_cnt !== 1) begin failures++; $display("FAIL perr_count: got %0d expected 1", par_cnt); end
    checks++;
    if (vld_cnt !== 0 || stp_cnt !== 0) begin
      failures++; $display("FAIL perr_other: vld %0d stp %0d expected 0 0", vld_cnt, stp_cnt);
    end
    checks++;
    if (p_data !== 8'h3C) begin failures++; $display("FAIL perr_hold: got 0x%02h expected 0x3C", p_data); end
  endtask

  task automatic test_back_to_back();
    prescale = 6'd32; par_en = 1'b0; par_typ = PAR_EVEN;
    clear_mon();
    exp_q.push_back(8'h0F);
    send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h0F, 32, 1'b0, 1'b0, 1'b1, -1);
    idle(8);
    checks++;
    if (stp_cnt !== 1) begin failures++; $display("FAIL b2b_stp_count: got %0d expected 1", stp_cnt); end
    checks++;
    if (vld_cnt !== 1 || par_cnt !== 0) begin
      failures++; $display("FAIL b2b_pulses: vld %0d par %0d expected 1 0", vld_cnt, par_cnt);
    end
    checks++;
    if (vld_cyc - fall_cyc !== 322) begin failures++; $display("FAIL b2b_latency: got %0d expected 322", vld_cyc - fall_cyc); end
    check_byte("b2b_data");
  endtask

  task automatic test_glitch();
    prescale = 6'd16; par_en = 1'b0;
    clear_mon();
    drive_bit(1'b0, 3);
    idle(40);
    checks++;
    if (vld_cnt + par_cnt + stp_cnt !== 0) begin
      failures++; $display("FAIL glitch_pulses: got %0d expected 0", vld_cnt + par_cnt + stp_cnt);
    end
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL glitch_state: got %0d expected IDLE", dut.state); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 3);
    idle(8);
    checks++;
    if (vld_cnt !== 1 || stp_cnt !== 0) begin
      failures++; $display("FAIL vote_pulses: vld %0d stp %0d expected 1 0", vld_cnt, stp_cnt);
    end
    check_byte("vote_data");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hF0;
    prescale = 6'd8; par_en = 1'b0;
    clear_mon();
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    rx_in = d[4];
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({p_data, data_vld, par_err, stp_err} !== 11'd0) begin
      failures++; $display("FAIL midrst_outputs: got 0x%03h expected 0x000", {p_data, data_vld, par_err, stp_err});
    end
    checks++;
    if (dut.state !== IDLE) begin failures++; $display("FAIL midrst_state: got %0d expected IDLE", dut.state); end
    @(negedge clk);
    rx_in = 1'b1;
    rst = 1'b0;
    idle(20);
    checks++;
    if (vld_cnt + par_cnt + stp_cnt !== 0) begin
      failures++; $display("FAIL midrst_aborted: got %0d pulses expected 0", vld_cnt + par_cnt + stp_cnt);
    end
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, -1);
    idle(8);
    checks++;
    if (vld_cnt !== 1) begin failures++; $display("FAIL midrst_vld_count: got %0d expected 1", vld_cnt); end
    check_byte("midrst_data");
  endtask

  initial begin
    test_reset();
    test_p8_no_parity();
    test_parity_ok();
    test_parity_error();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
